// File: rtl/nios2_fp_cpu_mulx_seq_if.sv
// nios2_fp_cpu_mulx_seq_if
//   Handshake and data bundle between the M-stage operand latch and the
//   multiply sequencer.
//
//   start  : request, sampled by the sequencer only while busy=0
//   kill   : pipeline flush, abandons any in-flight op
//   op     : 00 mul, 01 mulxuu, 10 mulxsu, 11 mulxss
//   src1   : operand A (32 bit)
//   src2   : operand B (32 bit)
//   busy   : op in flight
//   done   : one-cycle result-valid pulse
//   result : registered result, held until the next done
//
//   master : requester side (pipeline / testbench)
//   slave  : sequencer side
interface nios2_fp_cpu_mulx_seq_if;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, kill, op, src1, src2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, src1, src2,
        output busy, done, result
    );
endinterface

// File: rtl/nios2_fp_cpu_mulx_seq.sv
// nios2_fp_cpu_mulx_seq
//   Multicycle 32x32 multiply sequencer built around one 16x16 unsigned
//   multiplier cell with a single product register stage. Produces the low
//   word (mul) or the high word (mulxuu / mulxsu / mulxss) of the 64-bit
//   product.
//
//   Ports:
//     clk    : single clock, all state updates on the rising edge
//     reset  : synchronous, active-high
//     bus    : nios2_fp_cpu_mulx_seq_if.slave (start, kill, op, src1, src2,
//              busy, done, result)
//
//   Configuration macro: MULX_SIGNED_EN
//     defined   : signed high-word correction in a FIX state, latency 6
//     undefined : no FIX state, op[1] ignored (10/11 behave as 01),
//                 result loaded on ACC exit, latency 5
//
//   Pipeline per op (start accepted at edge E0):
//     MUL idx0..3 : issue partial products A.lo*B.lo, A.hi*B.lo, A.lo*B.hi,
//                   A.hi*B.hi; the product register loads on the edge that
//                   ends each issue cycle
//     accumulator : adds the product register (shifted) one cycle later,
//                   so the last add happens on the edge that ends ACC
module nios2_fp_cpu_mulx_seq (
    input  logic                     clk,
    input  logic                     reset,
    nios2_fp_cpu_mulx_seq_if.slave   bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [1:0]  idx;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] prod;
    logic [1:0]  prod_sh;      // shift code of the product register: 0, 16, 32 bits
    logic [63:0] acc;
    logic [31:0] result_q;

    logic        accept;
    logic        add_en;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;
    logic [1:0]  issue_sh;
    logic [63:0] addend;
    logic [63:0] acc_sum;
    logic [1:0]  op_eff;

    // A new op is only taken when no op is in flight; kill always wins.
    assign accept = (state == ST_IDLE || state == ST_DONE) && bus.start && !bus.kill;

    // The product register holds a fresh partial product in MUL idx1..3 and
    // in ACC (the last one); MUL idx0 has nothing loaded yet.
    assign add_en = ((state == ST_MUL) && (idx != 2'd0)) || (state == ST_ACC);

`ifdef MULX_SIGNED_EN
    assign op_eff = bus.op;
`else
    // Without the signed path the signed high-word ops fold onto mulxuu.
    assign op_eff = bus.op[1] ? 2'b01 : bus.op;
`endif

    // Issue order: idx[0] selects the A half, idx[1] the B half. The shift
    // of each partial product is 16 * (number of high halves used).
    always_comb begin
        mul_a    = idx[0] ? a_q[31:16] : a_q[15:0];
        mul_b    = idx[1] ? b_q[31:16] : b_q[15:0];
        issue_sh = {1'b0, idx[0]} + {1'b0, idx[1]};
    end

    // The multiplier cell: unregistered inputs, output captured in prod.
    assign mul_p = mul_a * mul_b;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        addend = 64'h0;
        case (prod_sh)
            2'd0:    addend = {32'h0, prod};
            2'd1:    addend = {16'h0, prod, 16'h0};
            default: addend = {prod, 32'h0};
        endcase
    end

    // 64-bit wraparound: carries out of bit 63 are dropped.
    assign acc_sum = acc + addend;

`ifdef MULX_SIGNED_EN
    // Signed high-word correction modulo 2^32:
    //   signed A contributes -B*2^32 when A is negative,
    //   signed B contributes -A*2^32 when B is negative.
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] fix_hi;
    logic [31:0] fix_result;

    always_comb begin
        corr_a     = (op_q[1] && a_q[31]) ? b_q : 32'h0;
        corr_b     = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'h0;
        fix_hi     = acc[63:32] - corr_a - corr_b;
        fix_result = (op_q == 2'b00) ? acc[31:0] : fix_hi;
    end
`endif

    always_comb begin
        state_next = state;
        if (bus.kill) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) state_next = ST_MUL;
                ST_MUL:  if (idx == 2'd3) state_next = ST_ACC;
`ifdef MULX_SIGNED_EN
                ST_ACC:  state_next = ST_FIX;
                ST_FIX:  state_next = ST_DONE;
`else
                ST_ACC:  state_next = ST_DONE;
`endif
                ST_DONE: state_next = bus.start ? ST_MUL : ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of the
    // statement order within the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            op_q     <= 2'b00;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            prod     <= 32'h0;
            prod_sh  <= 2'd0;
            acc      <= 64'h0;
            result_q <= 32'h0;
        end else begin
            state <= state_next;

            if (accept) begin
                op_q <= op_eff;
                a_q  <= bus.src1;
                b_q  <= bus.src2;
                idx  <= 2'd0;
                acc  <= 64'h0;
            end else begin
                if (state == ST_MUL) begin
                    idx <= idx + 2'd1;
                end
                if (add_en) begin
                    acc <= acc_sum;
                end
            end

            if (state == ST_MUL) begin
                prod    <= mul_p;
                prod_sh <= issue_sh;
            end

`ifdef MULX_SIGNED_EN
            if ((state == ST_FIX) && !bus.kill) begin
                result_q <= fix_result;
            end
`else
            // Final accumulation and result selection share the ACC exit edge.
            if ((state == ST_ACC) && !bus.kill) begin
                result_q <= (op_q == 2'b00) ? acc_sum[31:0] : acc_sum[63:32];
            end
`endif
        end
    end

    // Status is decoded from the state register, so it resets to 0 with it.
    assign bus.busy   = (state == ST_MUL) || (state == ST_ACC) || (state == ST_FIX);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_nios2_fp_cpu_mulx_seq.sv
// tb_nios2_fp_cpu_mulx_seq
//   Directed testbench for nios2_fp_cpu_mulx_seq. Expected results and
//   latencies are hand-computed; the build with or without MULX_SIGNED_EN
//   selects the matching latency and signed-op expectations.
module tb_nios2_fp_cpu_mulx_seq;

`ifdef MULX_SIGNED_EN
    localparam int          LAT          = 6;
    localparam logic [31:0] EXP_FF_SS    = 32'h0000_0000;
    localparam logic [31:0] EXP_80_SS    = 32'h4000_0000;
    localparam logic [31:0] EXP_80_SU    = 32'hC000_0000;
`else
    localparam int          LAT          = 5;
    localparam logic [31:0] EXP_FF_SS    = 32'hFFFF_FFFE;
    localparam logic [31:0] EXP_80_SS    = 32'h4000_0000;
    localparam logic [31:0] EXP_80_SU    = 32'h4000_0000;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;
    int   n2;
    int   extra;

    nios2_fp_cpu_mulx_seq_if bus ();

    nios2_fp_cpu_mulx_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; n counts edges after the accepting edge.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int cnt;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(cnt);
        check({tag, "_lat"}, 32'(cnt), 32'(LAT));
        check({tag, "_res"}, bus.result, exp);
        step();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = 2'b00;
        bus.src1  = 32'h0;
        bus.src2  = 32'h0;
        step();
        step();
        check("rst_busy",   {31'h0, bus.busy}, 32'h0);
        check("rst_done",   {31'h0, bus.done}, 32'h0);
        check("rst_result", bus.result,        32'h0);
        reset = 1'b0;
        step();

        // Main function across ops and operand patterns.
        run_op("mul_small",    2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
        run_op("mulxuu_small", 2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002);
        run_op("mul_ff",       2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulxuu_ff",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulxss_ff",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_FF_SS);
        run_op("mulxss_80",    2'b11, 32'h8000_0000, 32'h8000_0000, EXP_80_SS);
        run_op("mulxsu_80",    2'b10, 32'h8000_0000, 32'h8000_0000, EXP_80_SU);

        // Back-to-back: second start lands in the DONE cycle; extra starts
        // while busy must be ignored.
        bus.op    = 2'b00;
        bus.src1  = 32'd3;
        bus.src2  = 32'd5;
        bus.start = 1'b1;
        step();
        bus.src1 = 32'd1;
        bus.src2 = 32'd1;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            bus.start = (n == 2 || n == 3);
            step();
            n++;
        end
        bus.start = 1'b0;
        check("b2b_first_lat", 32'(n), 32'(LAT));
        check("b2b_first_res", bus.result, 32'h0000_000F);
        bus.src1  = 32'd7;
        bus.src2  = 32'd9;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("b2b_busy", {31'h0, bus.busy}, 32'h1);
        wait_done(n2);
        check("b2b_second_lat", 32'(n2), 32'(LAT));
        check("b2b_second_res", bus.result, 32'h0000_003F);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        check("b2b_no_extra_done", 32'(extra), 32'h0);

        // Kill three edges after start with start held high on the same edge.
        bus.op    = 2'b00;
        bus.src1  = 32'h0001_0003;
        bus.src2  = 32'h0002_0005;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("kill_busy_before", {31'h0, bus.busy}, 32'h1);
        bus.kill  = 1'b1;
        bus.start = 1'b1;
        step();
        bus.kill  = 1'b0;
        bus.start = 1'b0;
        check("kill_busy",   {31'h0, bus.busy}, 32'h0);
        check("kill_done",   {31'h0, bus.done}, 32'h0);
        check("kill_result", bus.result,        32'h0000_003F);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        check("kill_no_done", 32'(extra), 32'h0);
        check("kill_result_held", bus.result, 32'h0000_003F);

        // Reset four edges after start, then a clean op with no residue.
        bus.op    = 2'b01;
        bus.src1  = 32'hFFFF_FFFF;
        bus.src2  = 32'hFFFF_FFFF;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy",   {31'h0, bus.busy}, 32'h0);
        check("rst_mid_done",   {31'h0, bus.done}, 32'h0);
        check("rst_mid_result", bus.result,        32'h0);
        step();
        run_op("after_rst", 2'b00, 32'd2, 32'd3, 32'h0000_0006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
